// File: rtl/fetch_stage.sv
// fetch_stage: one-outstanding instruction fetch FSM (REQ/WAIT/HOLD/DROP) driving imem_req/imem_addr from pc and filling the IF/ID register, with stall hold and redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_if_redirect,
  input  logic [31:0] ex_if_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr_data,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t state;
  logic [31:0] pc, req_pc, buf_data;
  assign imem_req  = state == S_REQ && !ex_if_redirect;
  assign imem_addr = pc;
  always_ff @(posedge clk)
    if (rst) begin
      state            <= S_REQ;
      pc               <= RESET_PC;
      req_pc           <= '0;
      buf_data         <= NOP_INSTR;
      if_id_instr_data <= NOP_INSTR;
      if_id_pc         <= '0;
      if_id_valid      <= 1'b0;
    end else if (ex_if_redirect) begin
      state            <= (state == S_WAIT || state == S_DROP) && !imem_rvalid ? S_DROP : S_REQ;
      pc               <= ex_if_target & ~32'd3;
      buf_data         <= NOP_INSTR;
      if_id_instr_data <= NOP_INSTR;
      if_id_valid      <= 1'b0;
    end else begin
      if (!stall) begin
        if_id_instr_data <= NOP_INSTR;
        if_id_pc         <= req_pc;
        if_id_valid      <= 1'b0;
      end
      case (state)
        S_REQ:
          if (imem_ready) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= S_WAIT;
          end
        S_WAIT:
          if (imem_rvalid) begin
            if (stall) begin
              buf_data <= imem_rdata;
              state    <= S_HOLD;
            end else begin
              if_id_instr_data <= imem_rdata;
              if_id_pc         <= req_pc;
              if_id_valid      <= 1'b1;
              state            <= S_REQ;
            end
          end
        S_HOLD:
          if (!stall) begin
            if_id_instr_data <= buf_data;
            if_id_pc         <= req_pc;
            if_id_valid      <= 1'b1;
            state            <= S_REQ;
          end
        default:
          if (imem_rvalid) state <= S_REQ;
      endcase
    end
endmodule
